// File: rtl/vga_timing_ctrl.sv
// Raster timing master for the DE0 VGA path.
// Free-running h/v scan counters drive the X/Y coordinates for the pattern
// generator. Active/sync decode is delayed to line up with the generator's
// registered colour. The colour is saturated to 4 bits and gated by blank
// before it reaches the DAC pins. A one-clock strobe marks the start of
// vertical blanking for the game logic.
module vga_timing_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIPE_LAT = 1
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  output logic [9:0] oVGA_X,
  output logic [9:0] oVGA_Y,
  input  logic [9:0] iRed,
  input  logic [9:0] iGreen,
  input  logic [9:0] iBlue,
  output logic [3:0] oVGA_R,
  output logic [3:0] oVGA_G,
  output logic [3:0] oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oBLANK_n,
  output logic       oVBLANK_STB
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode boundaries sized to the counter width so every compare is 10-bit.
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYN_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYN_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYN_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYN_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nxt, v_nxt;
  logic       h_wrap;
  logic       act_c, hs_c, vs_c;

  // One bit per stage; bit 0 is the newest, bit PIPE_LAT-1 feeds the pins.
  logic [PIPE_LAT-1:0] act_sr, hs_sr, vs_sr;

  // Clamp a 10-bit colour to the 4-bit DAC range rather than wrapping it.
  function automatic logic [3:0] sat4(input logic [9:0] c);
    return (c > 10'd15) ? 4'hf : c[3:0];
  endfunction

  // Next counter position; v advances only on the h wrap so (last,last) -> (0,0).
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_nxt  = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_nxt  = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Scan counter registers.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  assign oVGA_X = h_cnt;
  assign oVGA_Y = v_cnt;

  // Active/sync decode of the current counter position (sync as "asserted", not pin level).
  always_comb begin
    act_c = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    hs_c  = (h_cnt >= H_SYN_BEG) && (h_cnt < H_SYN_END);
    vs_c  = (v_cnt >= V_SYN_BEG) && (v_cnt < V_SYN_END);
  end

  // Delay line matching the pattern generator latency; resets to blank / not-in-sync.
  if (PIPE_LAT == 1) begin : g_pipe_one
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
        act_sr <= '0;
        hs_sr  <= '0;
        vs_sr  <= '0;
      end else begin
        act_sr <= act_c;
        hs_sr  <= hs_c;
        vs_sr  <= vs_c;
      end
    end
  end else begin : g_pipe_multi
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
        act_sr <= '0;
        hs_sr  <= '0;
        vs_sr  <= '0;
      end else begin
        act_sr <= {act_sr[PIPE_LAT-2:0], act_c};
        hs_sr  <= {hs_sr[PIPE_LAT-2:0], hs_c};
        vs_sr  <= {vs_sr[PIPE_LAT-2:0], vs_c};
      end
    end
  end

  // Pin register: colour is sampled on the same edge as the last sync stage so
  // colour, sync and blank for one pixel leave together.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oVGA_R   <= 4'd0;
      oVGA_G   <= 4'd0;
      oVGA_B   <= 4'd0;
      oVGA_HS  <= ~SYNC_POL;
      oVGA_VS  <= ~SYNC_POL;
      oBLANK_n <= 1'b0;
    end else begin
      oVGA_R   <= act_sr[PIPE_LAT-1] ? sat4(iRed)   : 4'd0;
      oVGA_G   <= act_sr[PIPE_LAT-1] ? sat4(iGreen) : 4'd0;
      oVGA_B   <= act_sr[PIPE_LAT-1] ? sat4(iBlue)  : 4'd0;
      oVGA_HS  <= hs_sr[PIPE_LAT-1] ? SYNC_POL : ~SYNC_POL;
      oVGA_VS  <= vs_sr[PIPE_LAT-1] ? SYNC_POL : ~SYNC_POL;
      oBLANK_n <= act_sr[PIPE_LAT-1];
    end
  end

  // Frame strobe: fires on the edge that moves the counters to (0, V_ACTIVE);
  // undelayed so game logic gets the whole blanking interval.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oVBLANK_STB <= 1'b0;
    end else begin
      oVBLANK_STB <= (h_nxt == 10'd0) && (v_nxt == V_ACT_END);
    end
  end

endmodule
